// File: rtl/exec_alu_stage.sv
// Execute stage feeding the 8x16 register file write port; single-cycle ALU ops plus
// an optional 16-cycle shift-add MUL built only when EXEC_ALU_MUL_EN is defined.
module exec_alu_stage #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [RADDR_W-1:0] rd,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               reg_write,
  output logic [RADDR_W-1:0] write_reg,
  output logic [WIDTH-1:0]   write_data,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               illegal_op
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  logic               accept_s;
  logic [WIDTH:0]     add_s, sub_s, shl_s, shr_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_carry_s, alu_carry_upd_s, alu_legal_s;
  logic               is_mul_s, mul_busy_s, mul_done_s;
  logic [WIDTH-1:0]   mul_res_s;
  logic [RADDR_W-1:0] mul_rd_s;
  logic               wr_en_s, carry_upd_s, illegal_s;
  logic [RADDR_W-1:0] wr_reg_s;
  logic [WIDTH-1:0]   wr_data_s;

  logic               reg_write_r, zero_flag_r, carry_flag_r, illegal_op_r;
  logic [RADDR_W-1:0] write_reg_r;
  logic [WIDTH-1:0]   write_data_r;

  assign accept_s = in_valid && in_ready;
  assign in_ready = !mul_busy_s;

  // Single-cycle result, carry and legality of the presented opcode
  always_comb begin
    add_s           = {1'b0, a} + {1'b0, b};
    sub_s           = {1'b0, a} - {1'b0, b};
    shl_s           = {1'b0, a} << b[3:0];
    shr_s           = {a, 1'b0} >> b[3:0];
    alu_res_s       = '0;
    alu_carry_s     = 1'b0;
    alu_carry_upd_s = 1'b0;
    alu_legal_s     = 1'b1;
    case (op)
      OP_ADD: begin alu_res_s = add_s[WIDTH-1:0]; alu_carry_s = add_s[WIDTH]; alu_carry_upd_s = 1'b1; end
      OP_SUB: begin alu_res_s = sub_s[WIDTH-1:0]; alu_carry_s = sub_s[WIDTH]; alu_carry_upd_s = 1'b1; end
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_SHL: begin alu_res_s = shl_s[WIDTH-1:0]; alu_carry_s = shl_s[WIDTH]; alu_carry_upd_s = 1'b1; end
      OP_SHR: begin alu_res_s = shr_s[WIDTH:1]; alu_carry_s = shr_s[0]; alu_carry_upd_s = 1'b1; end
      OP_MOV: alu_res_s = b;
`ifdef EXEC_ALU_MUL_EN
      OP_MUL: alu_legal_s = 1'b1;
`else
      OP_MUL: alu_legal_s = 1'b0;
`endif
      default: alu_legal_s = 1'b0;
    endcase
  end

`ifdef EXEC_ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   mul_a_r, mul_b_r, acc_r, mul_step_s;
  logic [RADDR_W-1:0] mul_rd_r;

  assign is_mul_s   = (op == OP_MUL);
  assign mul_busy_s = (state_r == ST_MUL);
  assign mul_done_s = (cnt_r == CNT_LAST);
  assign mul_step_s = acc_r + (mul_b_r[0] ? mul_a_r : {WIDTH{1'b0}});
  assign mul_res_s  = mul_step_s;
  assign mul_rd_s   = mul_rd_r;

  // MUL state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // MUL next state: leave IDLE on an unflushed MUL accept, return after the last bit or a flush
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s && is_mul_s && !flush) state_s = ST_MUL; else state_s = ST_IDLE;
      ST_MUL:  if (flush || mul_done_s) state_s = ST_IDLE; else state_s = ST_MUL;
      default: state_s = ST_IDLE;
    endcase
  end

  // Shift-add datapath, one multiplier bit per MUL cycle, LSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      acc_r    <= '0;
      mul_a_r  <= '0;
      mul_b_r  <= '0;
      mul_rd_r <= '0;
    end else if (state_r == ST_IDLE) begin
      if (accept_s && is_mul_s) begin
        cnt_r    <= '0;
        acc_r    <= '0;
        mul_a_r  <= a;
        mul_b_r  <= b;
        mul_rd_r <= rd;
      end
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
      acc_r   <= mul_step_s;
      mul_a_r <= mul_a_r << 1;
      mul_b_r <= mul_b_r >> 1;
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign mul_busy_s = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_res_s  = '0;
  assign mul_rd_s   = '0;
`endif

  // Output decode: next write-port, flag and illegal-pulse values
  always_comb begin
    wr_en_s     = 1'b0;
    wr_reg_s    = rd;
    wr_data_s   = alu_res_s;
    carry_upd_s = 1'b0;
    illegal_s   = 1'b0;
    if (flush) begin
      wr_en_s = 1'b0;
    end else if (mul_busy_s) begin
      wr_reg_s  = mul_rd_s;
      wr_data_s = mul_res_s;
      if (mul_done_s) wr_en_s = 1'b1;
      else            wr_en_s = 1'b0;
    end else if (accept_s) begin
      if (!alu_legal_s) begin
        illegal_s = 1'b1;
      end else if (!is_mul_s) begin
        wr_en_s     = 1'b1;
        carry_upd_s = alu_carry_upd_s;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Registered write port and flags; address/data hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_r  <= 1'b0;
      illegal_op_r <= 1'b0;
      write_reg_r  <= '0;
      write_data_r <= '0;
      zero_flag_r  <= 1'b0;
      carry_flag_r <= 1'b0;
    end else begin
      reg_write_r  <= wr_en_s;
      illegal_op_r <= illegal_s;
      if (wr_en_s) begin
        write_reg_r  <= wr_reg_s;
        write_data_r <= wr_data_s;
        zero_flag_r  <= (wr_data_s == {WIDTH{1'b0}});
        if (carry_upd_s) carry_flag_r <= alu_carry_s;
      end
    end
  end

  assign reg_write  = reg_write_r;
  assign write_reg  = write_reg_r;
  assign write_data = write_data_r;
  assign zero_flag  = zero_flag_r;
  assign carry_flag = carry_flag_r;
  assign illegal_op = illegal_op_r;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Scoreboard bench for exec_alu_stage: driver queues expected write/illegal events
// with their due cycle, a negedge monitor pops and compares whenever the DUT emits one.
module tb_exec_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [2:0]  rd = 3'd0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        flush = 1'b0;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        zero_flag, carry_flag, illegal_op;

  exec_alu_stage #(.WIDTH(16), .RADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .a(a), .b(b), .flush(flush),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          ill;
    logic [2:0]  r;
    logic [15:0] d;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  logic mz = 1'b0;
  logic mc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Monitor: every write pulse or illegal pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (reg_write || illegal_op) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", {30'd0, reg_write, illegal_op}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("event_cycle", cyc, e.due);
        chk("event_kind", {30'd0, reg_write, illegal_op}, {30'd0, !e.ill, e.ill});
        if (!e.ill) begin
          chk("write_reg", {29'd0, write_reg}, {29'd0, e.r});
          chk("write_data", {16'd0, write_data}, {16'd0, e.d});
        end
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [2:0] r, input logic fl);
    op = o; a = x; b = y; rd = r; flush = fl; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input int due, input bit ill, input logic [2:0] r, input logic [15:0] d,
                      input logic z, input logic c);
    exp_t e;
    e.due = due; e.ill = ill; e.r = r; e.d = d; e.z = z; e.c = c;
    sbq.push_back(e);
  endtask

  // single-cycle op with hand-computed result and flags
  task automatic alu(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [2:0] r, input logic [15:0] d, input logic z, input logic c);
    wait_ready();
    push(cyc + 1, 1'b0, r, d, z, c);
    mz = z; mc = c;
    drive(o, x, y, r, 1'b0);
  endtask

  task automatic ill(input logic [3:0] o);
    wait_ready();
    push(cyc + 1, 1'b1, 3'd0, 16'h0000, mz, mc);
    drive(o, 16'h1111, 16'h2222, 3'd5, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_data", {16'd0, write_data}, 32'd0);
    chk("rst_write_reg", {29'd0, write_reg}, 32'd0);
    chk("rst_flags", {29'd0, zero_flag, carry_flag, illegal_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    alu(4'd0, 16'hFFFF, 16'h0001, 3'd3, 16'h0000, 1'b1, 1'b1);
    alu(4'd1, 16'h0005, 16'h0007, 3'd4, 16'hFFFE, 1'b0, 1'b1);
    alu(4'd5, 16'h8001, 16'h0001, 3'd1, 16'h0002, 1'b0, 1'b1);
    alu(4'd6, 16'h0003, 16'h0001, 3'd5, 16'h0001, 1'b0, 1'b1);
    alu(4'd2, 16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 1'b0, 1'b1);
    alu(4'd3, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b1);
    alu(4'd4, 16'hAAAA, 16'h5555, 3'd7, 16'hFFFF, 1'b0, 1'b1);
    alu(4'd0, 16'h1234, 16'h0001, 3'd0, 16'h1235, 1'b0, 1'b0);
    alu(4'd1, 16'h0007, 16'h0005, 3'd6, 16'h0002, 1'b0, 1'b0);
    alu(4'd5, 16'h4000, 16'h0002, 3'd1, 16'h0000, 1'b1, 1'b1);
    alu(4'd6, 16'h0001, 16'h0000, 3'd2, 16'h0001, 1'b0, 1'b0);
    alu(4'd0, 16'h8000, 16'h8001, 3'd3, 16'h0001, 1'b0, 1'b1);
    ill(4'd12);
    ill(4'd15);

`ifdef EXEC_ALU_MUL_EN
    wait_ready();
    push(cyc + 17, 1'b0, 3'd6, 16'h4E6F, 1'b0, mc);
    mz = 1'b0;
    drive(4'd8, 16'h0123, 16'h0045, 3'd6, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("mul_done_ready", {31'd0, in_ready}, 32'd1);

    wait_ready();
    push(cyc + 17, 1'b0, 3'd4, 16'h0000, 1'b1, mc);
    mz = 1'b1;
    drive(4'd8, 16'h1234, 16'h0000, 3'd4, 1'b0);

    wait_ready();
    drive(4'd8, 16'h00FF, 16'h0101, 3'd5, 1'b0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ready_after_flush", {31'd0, in_ready}, 32'd1);
    alu(4'd7, 16'h0000, 16'h1234, 3'd2, 16'h1234, 1'b0, mc);
`else
    ill(4'd8);
    alu(4'd7, 16'h0000, 16'h1234, 3'd2, 16'h1234, 1'b0, mc);
`endif

    wait_ready();
    drive(4'd7, 16'h0000, 16'hBEEF, 3'd5, 1'b1);
    repeat (3) @(negedge clk);

    wait_ready();
`ifdef EXEC_ALU_MUL_EN
    drive(4'd8, 16'h0005, 16'h0007, 3'd1, 1'b0);
`else
    drive(4'd0, 16'h0005, 16'h0007, 3'd1, 1'b1);
`endif
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {29'd0, reg_write, illegal_op, 1'b0}, 32'd0);
    chk("midrst_flags", {30'd0, zero_flag, carry_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mz = 1'b0; mc = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", {31'd0, in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    chk("flags_after_midrst", {30'd0, zero_flag, carry_flag}, 32'd0);

    alu(4'd0, 16'h0001, 16'h0002, 3'd7, 16'h0003, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
